// File: rtl/aes_pkg.sv
// aes_pkg: shared AES definitions for the SubBytes/ShiftRows stage,
// MixColumns and the round controller.
//   - state geometry constants
//   - 2-bit FSM state encoding for iterative stages
//   - forward S-box table
//   - inverse S-box table, only when AES_SUB_SHIFT_INV_EN is defined
//   - get_byte(): pulls row r of column c out of a 128-bit state
//     (column c = bits [127-32c -: 32], row r = byte r inside that column).
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_NCOLS   = 4;
    localparam int AES_NROWS   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_e;

    // Index 0 is the leftmost byte, so the table reads like FIPS-197.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

`ifdef AES_SUB_SHIFT_INV_EN
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };
`endif

    function automatic logic [7:0] get_byte(input logic [127:0] s,
                                            input logic [1:0]   col,
                                            input logic [1:0]   row);
        return s[8*(15 - 4*int'(col) - int'(row)) +: 8];
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational 8-bit AES S-box lookup.
//   din  - input byte
//   inv  - 1 selects the inverse S-box (port exists only with AES_SUB_SHIFT_INV_EN)
//   dout - substituted byte
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] din,
`ifdef AES_SUB_SHIFT_INV_EN
    input  logic       inv,
`endif
    output logic [7:0] dout
);

`ifdef AES_SUB_SHIFT_INV_EN
    assign dout = inv ? INV_SBOX[din] : SBOX[din];
`else
    assign dout = SBOX[din];
`endif

endmodule

// File: rtl/sub_shift_rows_seq.sv
// sub_shift_rows_seq: iterative AES SubBytes + ShiftRows, COLS_PER_CYCLE
// output columns per busy cycle using 4*COLS_PER_CYCLE shared S-boxes.
// Optional macro AES_SUB_SHIFT_INV_EN adds the inv port (InvShiftRows +
// InvSubBytes, sampled with the block).
//   clk, rst_n           - clock, async active-low reset
//   in_valid/in_ready    - upstream handshake, state_in sampled on accept
//   out_valid/out_ready  - downstream handshake, state_out held until taken
module sub_shift_rows_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1   // 1, 2 or 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
`ifdef AES_SUB_SHIFT_INV_EN
    input  logic         inv,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out
);

    fsm_e         fsm_q, fsm_nxt;
    logic [1:0]   cnt;
    logic [2:0]   cnt_sum;
    logic         last_col;
    logic [127:0] cap;
    logic [127:0] so_nxt;
    logic         accept;

    logic [COLS_PER_CYCLE-1:0][1:0]      col_idx;
    logic [COLS_PER_CYCLE-1:0][3:0][7:0] sb_out;
    logic [COLS_PER_CYCLE-1:0][31:0]     col_data;

`ifdef AES_SUB_SHIFT_INV_EN
    logic inv_q;
`endif

    assign in_ready  = (fsm_q == IDLE);
    assign out_valid = (fsm_q == DONE);
    assign accept    = in_valid && in_ready;

    // cnt is always a multiple of COLS_PER_CYCLE, so a 3-bit sum of 4
    // marks the final group of columns.
    assign cnt_sum  = {1'b0, cnt} + 3'(COLS_PER_CYCLE);
    assign last_col = (cnt_sum == 3'd4);

    for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_col
        assign col_idx[j]  = cnt + 2'(j);
        assign col_data[j] = {sb_out[j][0], sb_out[j][1], sb_out[j][2], sb_out[j][3]};
        for (genvar r = 0; r < AES_NROWS; r++) begin : g_row
            logic [1:0] src;
            logic [7:0] din;
            // ShiftRows folded into the read: row r comes from column c+r
            // (c-r for the inverse); mod 4 falls out of 2-bit arithmetic.
`ifdef AES_SUB_SHIFT_INV_EN
            assign src = inv_q ? col_idx[j] - 2'(r) : col_idx[j] + 2'(r);
`else
            assign src = col_idx[j] + 2'(r);
`endif
            assign din = get_byte(cap, src, 2'(r));
            aes_sbox u_sbox (
                .din  (din),
`ifdef AES_SUB_SHIFT_INV_EN
                .inv  (inv_q),
`endif
                .dout (sb_out[j][r])
            );
        end
    end

    // Only the columns being produced this cycle change; the rest hold.
    always_comb begin
        so_nxt = state_out;
        for (int j = 0; j < COLS_PER_CYCLE; j++)
            so_nxt[32*(3 - int'(col_idx[j])) +: 32] = col_data[j];
    end

    always_comb begin
        fsm_nxt = fsm_q;
        case (fsm_q)
            IDLE:    if (in_valid)  fsm_nxt = BUSY;
            BUSY:    if (last_col)  fsm_nxt = DONE;
            DONE:    if (out_ready) fsm_nxt = IDLE;
            default:                fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm_q <= IDLE;
        else        fsm_q <= fsm_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            cap       <= '0;
            state_out <= '0;
`ifdef AES_SUB_SHIFT_INV_EN
            inv_q     <= 1'b0;
`endif
        end else if (accept) begin
            cnt <= '0;
            cap <= state_in;
`ifdef AES_SUB_SHIFT_INV_EN
            inv_q <= inv;
`endif
        end else if (fsm_q == BUSY) begin
            cnt       <= cnt_sum[1:0];
            state_out <= so_nxt;
        end
    end

endmodule

// File: tb/tb_sub_shift_rows_seq.sv
// tb_sub_shift_rows_seq: drives three instances (COLS_PER_CYCLE = 1, 2, 4)
// and checks them against an S-box model built from GF(2^8) arithmetic.
// Build with +define+AES_SUB_SHIFT_INV_EN to include the inverse checks.
module tb_sub_shift_rows_seq;

    logic         clk;
    logic         rst_n;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] state_in  [3];
    logic         inv_s     [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] state_out [3];

    int n_cmp = 0;
    int n_bad = 0;
    int lat_of [3] = '{4, 2, 1};

    logic [7:0] fs [256];
    logic [7:0] is [256];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sub_shift_rows_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .state_in  (state_in[g]),
`ifdef AES_SUB_SHIFT_INV_EN
            .inv       (inv_s[g]),
`endif
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .state_out (state_out[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box = affine transform of the multiplicative inverse (x^254).
    function automatic logic [7:0] sbox_math(input logic [7:0] x);
        logic [7:0] y = 8'h01;
        for (int i = 0; i < 254; i++) y = gmul(y, x);
        return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]}
                 ^ {y[3:0], y[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] getb(input logic [127:0] s, input int c, input int r);
        return s[127 - 32*c - 8*r -: 8];
    endfunction

    function automatic logic [127:0] ref_out(input logic [127:0] s, input logic iv);
        logic [127:0] o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 32*c - 8*r -: 8] = iv ? is[getb(s, (c - r + 4) % 4, r)]
                                              : fs[getb(s, (c + r) % 4, r)];
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus helpers ----------------
    // Called just after a rising edge; leaves the DUT back in IDLE.
    task automatic run_block(input int k, input logic [127:0] d, input logic iv,
                             input string tag);
        int n;
        logic [127:0] expv;
        expv = ref_out(d, iv);
        chk({tag, "_in_ready"}, 128'(in_ready[k]), 128'(1));
        in_valid[k] = 1'b1; state_in[k] = d; inv_s[k] = iv;
        @(posedge clk); #1;
        // Later input changes must not leak into the result.
        in_valid[k] = 1'b0; state_in[k] = rnd128(); inv_s[k] = ~iv;
        n = 0;
        while (!out_valid[k] && n < 20) begin @(posedge clk); #1; n++; end
        chk({tag, "_latency"}, 128'(n), 128'(lat_of[k]));
        chk({tag, "_data"}, state_out[k], expv);
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
        chk({tag, "_back_idle"}, {126'd0, out_valid[k], in_ready[k]}, 128'd1);
    endtask

    initial begin
        int n;
        logic rdy;
        logic [127:0] a, b, expv;

        for (int i = 0; i < 256; i++) fs[i] = sbox_math(8'(i));
        for (int i = 0; i < 256; i++) is[fs[i]] = 8'(i);

        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0; state_in[k] = '0; inv_s[k] = 1'b0; out_ready[k] = 1'b0;
        end
        rst_n = 1'b0;
        #12;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_out_%0d", k), state_out[k], 128'd0);
            chk($sformatf("reset_hs_%0d", k), {126'd0, out_valid[k], in_ready[k]}, 128'd1);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // FIPS-197 App. B round 1, plus its expected value as a constant.
        run_block(0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, "fips");
        chk("fips_model", ref_out(128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0),
            128'hd4bf5d30e0b452aeb84111f11e2798e5);

        for (int k = 0; k < 3; k++) begin
            run_block(k, 128'd0, 1'b0, $sformatf("zero_%0d", k));
            chk($sformatf("zero_const_%0d", k), state_out[k], {16{8'h63}});
        end

        for (int i = 0; i < 6; i++)
            for (int k = 0; k < 3; k++)
                run_block(k, rnd128(), 1'b0, $sformatf("rand_%0d_%0d", k, i));

        // Backpressure: new data offered while the result is held.
        a = rnd128(); expv = ref_out(a, 1'b0);
        in_valid[0] = 1'b1; state_in[0] = a;
        @(posedge clk); #1;
        state_in[0] = rnd128();
        n = 0;
        while (!out_valid[0] && n < 20) begin @(posedge clk); #1; n++; end
        chk("bp_latency", 128'(n), 128'(4));
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp_hold_hs_%0d", i), {126'd0, out_valid[0], in_ready[0]}, 128'd2);
            chk($sformatf("bp_hold_data_%0d", i), state_out[0], expv);
            state_in[0] = rnd128();
            @(posedge clk); #1;
        end
        in_valid[0] = 1'b0; out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        chk("bp_release", {126'd0, out_valid[0], in_ready[0]}, 128'd1);
        chk("bp_no_recapture", state_out[0], expv);

        // Back-to-back on the 2-column instance.
        a = rnd128(); b = rnd128();
        out_ready[1] = 1'b1; in_valid[1] = 1'b1; state_in[1] = a;
        @(posedge clk); #1;
        state_in[1] = b;
        n = 0;
        while (!out_valid[1] && n < 20) begin @(posedge clk); #1; n++; end
        chk("b2b_lat_a", 128'(n), 128'(2));
        chk("b2b_data_a", state_out[1], ref_out(a, 1'b0));
        n = 0;
        do begin
            rdy = in_ready[1];
            @(posedge clk); #1; n++;
        end while (!rdy && n < 20);
        chk("b2b_accept_gap", 128'(n), 128'(2));
        in_valid[1] = 1'b0;
        n = 0;
        while (!out_valid[1] && n < 20) begin @(posedge clk); #1; n++; end
        chk("b2b_lat_b", 128'(n), 128'(2));
        chk("b2b_data_b", state_out[1], ref_out(b, 1'b0));
        @(posedge clk); #1;
        out_ready[1] = 1'b0;

        // Reset during the second BUSY cycle.
        in_valid[0] = 1'b1; state_in[0] = rnd128();
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out", state_out[0], 128'd0);
        chk("rst_mid_hs", {126'd0, out_valid[0], in_ready[0]}, 128'd1);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run_block(0, rnd128(), 1'b0, "post_rst");

`ifdef AES_SUB_SHIFT_INV_EN
        run_block(0, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1, "inv_fips");
        chk("inv_fips_const", state_out[0], 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 3; k++)
                run_block(k, rnd128(), 1'b1, $sformatf("inv_rand_%0d_%0d", k, i));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
